// File: rtl/crc_pkg.sv
// Shared CRC-3 definitions for the generator and checker (poly x^3+x+1).
package crc_pkg;

  localparam int CRC_W = 3;
  // Full polynomial; the x^3 term is implicit in the step function.
  localparam logic [CRC_W:0] POLY = 4'b1011;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // One bit of polynomial long division: shift in b, reduce if x^3 falls out.
  function automatic logic [CRC_W-1:0] crc3_step(input logic [CRC_W-1:0] rem, input logic b);
    return {rem[CRC_W-2:0], b} ^ (rem[CRC_W-1] ? POLY[CRC_W-1:0] : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/crc_check.sv
// Serial CRC-3 checker: divides {data,crc} one bit per cycle, MSB first, and
// reports pass/syndrome plus a saturating failure count.
module crc_check
  import crc_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CRC_W-1:0]  i_crc,
  input  logic              clr_cnt,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_pass,
  output logic [CRC_W-1:0]  o_syndrome,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam int CODE_W = DATA_W + CRC_W;
  localparam int BIT_W  = $clog2(CODE_W);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(CODE_W - 1);

  state_t             state, state_nxt;
  logic [CODE_W-1:0]  shift;
  logic [CRC_W-1:0]   rem, rem_nxt;
  logic [BIT_W-1:0]   cnt;
  logic               last;

  assign rem_nxt = crc3_step(rem, shift[CODE_W-1]);
  // Result edge: the final codeword bit is being consumed.
  assign last    = (state == CHECK) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start on en from IDLE, return after the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)   state_nxt = CHECK;
      CHECK:   if (last) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register (glitch-free, effectively registered).
  always_comb begin
    o_busy = (state == CHECK);
  end

  // Datapath: load codeword, shift-divide, publish result on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      rem        <= '0;
      cnt        <= '0;
      o_valid    <= 1'b0;
      o_pass     <= 1'b0;
      o_syndrome <= '0;
    end else begin
      o_valid <= 1'b0;
      if (state == IDLE && en) begin
        shift <= {i_data, i_crc};
        rem   <= '0;
        cnt   <= '0;
      end else if (state == CHECK) begin
        shift <= {shift[CODE_W-2:0], 1'b0};
        rem   <= rem_nxt;
        cnt   <= cnt + 1'b1;
        if (last) begin
          o_valid    <= 1'b1;
          o_syndrome <= rem_nxt;
          o_pass     <= (rem_nxt == '0);
        end
      end
    end
  end

  // Saturating failure counter; clear wins over a coincident failure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     o_err_cnt <= '0;
    else if (clr_cnt)                            o_err_cnt <= '0;
    else if (last && rem_nxt != '0 && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
  end

endmodule
